// File: rtl/cdb_pkg.sv
// Shared types and helpers for the CDB transmit arbiter.
package cdb_pkg;

    localparam int ROB_IDX_W = 4;
    localparam int DATA_W    = 16;
    localparam int CDB_LANES = 4;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_index;
        logic [DATA_W-1:0]    result;
    } cdb_entry_t;

    function automatic int next_rr(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/cdb_if.sv
// Result-source and CDB broadcast signals. The master side is the functional units
// plus the consumers; the slave side is the arbiter.
interface cdb_if #(
    parameter int N_SRC   = 6,
    parameter int N_LANES = cdb_pkg::CDB_LANES
);
    import cdb_pkg::*;

    logic [N_SRC-1:0]     src_valid;
    logic [ROB_IDX_W-1:0] src_rob_index [N_SRC];
    logic [DATA_W-1:0]    src_result    [N_SRC];
    logic [N_SRC-1:0]     src_ready;

    logic [N_LANES-1:0]   cdb_valid;
    logic [ROB_IDX_W-1:0] cdb_rob_index [N_LANES];
    logic [DATA_W-1:0]    cdb_result    [N_LANES];
    logic                 cdb_busy;
    logic                 dup_err;

    modport master (
        output src_valid, src_rob_index, src_result,
        input  src_ready, cdb_valid, cdb_rob_index, cdb_result, cdb_busy, dup_err
    );

    modport slave (
        input  src_valid, src_rob_index, src_result,
        output src_ready, cdb_valid, cdb_rob_index, cdb_result, cdb_busy, dup_err
    );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: DEPTH-entry circular buffer with synchronous flush.
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  cdb_entry_t    push_data,
    input  logic          pop,
    output cdb_entry_t    head,
    output logic [CW-1:0] count,
    output logic          not_full,
    output logic          can_pop
);

    cdb_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pushed_last;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pushed_last <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            pushed_last <= push;
        end
    end

    // The entry written at the last edge is always the tail, so it is held back one
    // extra cycle before it may be granted.
    assign can_pop  = (count > CW'(pushed_last));
    assign not_full = (count < CW'(DEPTH));
    assign head     = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit arbiter: round-robin grant of up to N_LANES source FIFO heads onto
// registered lanes. Define CDB_DUP_CHECK_EN to build the sticky duplicate-tag check.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_SRC   = 6,
    parameter int N_LANES = CDB_LANES,
    parameter int DEPTH   = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    cdb_if.slave  bus
);

    localparam int PW = $clog2(N_SRC);
    localparam int CW = $clog2(DEPTH + 1);

    cdb_entry_t         head     [N_SRC];
    logic [CW-1:0]      count    [N_SRC];
    logic [N_SRC-1:0]   not_full;
    logic [N_SRC-1:0]   can_pop;
    logic [N_SRC-1:0]   nonempty;
    logic [N_SRC-1:0]   push;
    logic [N_SRC-1:0]   grant;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      rr_next;
    logic [N_LANES-1:0] lane_v;
    cdb_entry_t         lane_d   [N_LANES];

    for (genvar s = 0; s < N_SRC; s++) begin : g_src
        assign push[s]     = bus.src_valid[s] & not_full[s];
        assign nonempty[s] = (count[s] != '0);

        cdb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .push      (push[s]),
            .push_data ({bus.src_rob_index[s], bus.src_result[s]}),
            .pop       (grant[s]),
            .head      (head[s]),
            .count     (count[s]),
            .not_full  (not_full[s]),
            .can_pop   (can_pop[s])
        );
    end

    assign bus.src_ready = not_full;
    assign bus.cdb_busy  = |nonempty;

    always_comb begin
        int n;
        int idx;
        grant   = '0;
        lane_v  = '0;
        rr_next = rr_ptr;
        for (int k = 0; k < N_LANES; k++) lane_d[k] = '0;
        n   = 0;
        idx = int'(rr_ptr);
        for (int i = 0; i < N_SRC; i++) begin
            if (can_pop[idx] && n < N_LANES) begin
                grant[idx] = 1'b1;
                lane_v[n]  = 1'b1;
                lane_d[n]  = head[idx];
                rr_next    = PW'(next_rr(idx, N_SRC));
                n++;
            end
            idx = next_rr(idx, N_SRC);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rr_ptr        <= '0;
            bus.cdb_valid <= '0;
            for (int k = 0; k < N_LANES; k++) begin
                bus.cdb_rob_index[k] <= '0;
                bus.cdb_result[k]    <= '0;
            end
        end else begin
            rr_ptr        <= rr_next;
            bus.cdb_valid <= lane_v;
            for (int k = 0; k < N_LANES; k++) begin
                bus.cdb_rob_index[k] <= lane_d[k].rob_index;
                bus.cdb_result[k]    <= lane_d[k].result;
            end
        end
    end

`ifdef CDB_DUP_CHECK_EN
    logic dup_hit;

    always_comb begin
        dup_hit = 1'b0;
        for (int a = 0; a < N_LANES; a++) begin
            for (int b = a + 1; b < N_LANES; b++) begin
                if (lane_v[a] && lane_v[b] && lane_d[a].rob_index == lane_d[b].rob_index)
                    dup_hit = 1'b1;
            end
        end
    end

    // Flush suppresses the lane load, so it cannot raise the flag either.
    always_ff @(posedge clk) begin
        if (!rst_n)
            bus.dup_err <= 1'b0;
        else if (dup_hit && !flush)
            bus.dup_err <= 1'b1;
    end
`else
    assign bus.dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; expected values are hand-computed.
module tb_cdb_arbiter;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   errors;

`ifdef CDB_DUP_CHECK_EN
    localparam logic EXP_DUP = 1'b1;
`else
    localparam logic EXP_DUP = 1'b0;
`endif

    cdb_if #(.N_SRC(6), .N_LANES(4)) bus ();

    cdb_arbiter #(.N_SRC(6), .N_LANES(4), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int s, input logic [3:0] idx, input logic [15:0] res);
        bus.src_valid[s]     = 1'b1;
        bus.src_rob_index[s] = idx;
        bus.src_result[s]    = res;
    endtask

    task automatic clearStimulus();
        bus.src_valid = '0;
        for (int s = 0; s < 6; s++) begin
            bus.src_rob_index[s] = '0;
            bus.src_result[s]    = '0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // e_idx/e_res pack lane 3 in the top nibble/halfword down to lane 0 at the bottom.
    task automatic checkLanes(input string tag, input logic [3:0] ev,
                              input logic [15:0] e_idx, input logic [63:0] e_res);
        checkOutput({tag, "_valid"}, 32'(bus.cdb_valid), 32'(ev));
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s_idx%0d", tag, k), 32'(bus.cdb_rob_index[k]), 32'(e_idx[k*4 +: 4]));
            checkOutput($sformatf("%s_res%0d", tag, k), 32'(bus.cdb_result[k]), 32'(e_res[k*16 +: 16]));
        end
    endtask

    task automatic checkIdle(input string tag);
        checkLanes(tag, 4'b0000, 16'h0, 64'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        clearStimulus();

        $display("[TB] reset state");
        tick();
        tick();
        checkIdle("rst");
        checkOutput("rst_ready", 32'(bus.src_ready), 32'h3F);
        checkOutput("rst_busy", 32'(bus.cdb_busy), 32'h0);
        checkOutput("rst_dup", 32'(bus.dup_err), 32'h0);
        rst_n = 1'b1;
        tick();

        $display("[TB] single push latency");
        applyStimulus(2, 4'h5, 16'h1234);
        tick();
        clearStimulus();
        checkOutput("t1_valid_e1", 32'(bus.cdb_valid), 32'h0);
        checkOutput("t1_busy", 32'(bus.cdb_busy), 32'h1);
        tick();
        checkOutput("t1_valid_e2", 32'(bus.cdb_valid), 32'h0);
        tick();
        checkLanes("t1_e3", 4'b0001, 16'h0005, 64'h0000_0000_0000_1234);
        tick();
        checkIdle("t1_e4");
        checkOutput("t1_busy_end", 32'(bus.cdb_busy), 32'h0);

        $display("[TB] all sources push once");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int s = 0; s < 6; s++) applyStimulus(s, 4'(s), 16'hA000 + 16'(s));
        tick();
        clearStimulus();
        tick();
        checkOutput("t2_valid_e2", 32'(bus.cdb_valid), 32'h0);
        tick();
        checkLanes("t2_e3", 4'b1111, 16'h3210, 64'hA003_A002_A001_A000);
        tick();
        checkLanes("t2_e4", 4'b0011, 16'h0054, 64'h0000_0000_A005_A004);
        applyStimulus(0, 4'hA, 16'h00AA);
        applyStimulus(5, 4'hB, 16'h00BB);
        tick();
        clearStimulus();
        tick();
        tick();
        checkLanes("t2_rr0", 4'b0011, 16'h00BA, 64'h0000_0000_00BB_00AA);

        $display("[TB] source FIFO fill and hold");
        applyStimulus(1, 4'h7, 16'h0707);
        tick();
        checkOutput("t3_ready_p1", 32'(bus.src_ready), 32'h3F);
        applyStimulus(1, 4'h8, 16'h0808);
        tick();
        checkOutput("t3_ready_p2", 32'(bus.src_ready), 32'h3D);
        checkOutput("t3_valid_p2", 32'(bus.cdb_valid), 32'h0);
        applyStimulus(1, 4'h9, 16'h0909);
        tick();
        checkLanes("t3_first", 4'b0001, 16'h0007, 64'h0000_0000_0000_0707);
        checkOutput("t3_ready_pop", 32'(bus.src_ready), 32'h3F);
        tick();
        clearStimulus();
        checkLanes("t3_second", 4'b0001, 16'h0008, 64'h0000_0000_0000_0808);
        tick();
        checkIdle("t3_gap");
        tick();
        checkLanes("t3_third", 4'b0001, 16'h0009, 64'h0000_0000_0000_0909);
        tick();
        checkIdle("t3_end");

        $display("[TB] round-robin wrap from pointer 2");
        applyStimulus(0, 4'hC, 16'h0C0C);
        applyStimulus(1, 4'hD, 16'h0D0D);
        applyStimulus(2, 4'hE, 16'h0E0E);
        tick();
        clearStimulus();
        tick();
        tick();
        checkLanes("wrap", 4'b0111, 16'h0DCE, 64'h0000_0D0D_0C0C_0E0E);

        $display("[TB] flush with pending results");
        applyStimulus(0, 4'h1, 16'h1111);
        applyStimulus(1, 4'h2, 16'h2222);
        applyStimulus(2, 4'h3, 16'h3333);
        tick();
        clearStimulus();
        tick();
        flush = 1'b1;
        applyStimulus(4, 4'hF, 16'hFFFF);
        tick();
        flush = 1'b0;
        clearStimulus();
        checkIdle("t4_flush");
        checkOutput("t4_busy", 32'(bus.cdb_busy), 32'h0);
        checkOutput("t4_ready", 32'(bus.src_ready), 32'h3F);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("t4_quiet%0d", c), 32'(bus.cdb_valid), 32'h0);
        end

        $display("[TB] reset with full FIFOs");
        for (int s = 0; s < 6; s++) applyStimulus(s, 4'(s), 16'hB000 + 16'(s));
        tick();
        for (int s = 0; s < 6; s++) applyStimulus(s, 4'(s + 8), 16'hC000 + 16'(s));
        tick();
        clearStimulus();
        checkOutput("t5_full", 32'(bus.src_ready), 32'h00);
        rst_n = 1'b0;
        flush = 1'b1;
        tick();
        rst_n = 1'b1;
        flush = 1'b0;
        checkIdle("t5_rst");
        checkOutput("t5_ready", 32'(bus.src_ready), 32'h3F);
        checkOutput("t5_busy", 32'(bus.cdb_busy), 32'h0);
        checkOutput("t5_dup", 32'(bus.dup_err), 32'h0);
        tick();
        tick();
        checkOutput("t5_after", 32'(bus.cdb_valid), 32'h0);

        $display("[TB] duplicate tag");
        applyStimulus(0, 4'h6, 16'h6000);
        applyStimulus(3, 4'h6, 16'h6003);
        tick();
        clearStimulus();
        tick();
        checkOutput("t6_dup_pre", 32'(bus.dup_err), 32'h0);
        tick();
        checkLanes("t6_bcast", 4'b0011, 16'h0066, 64'h0000_0000_6003_6000);
        checkOutput("t6_dup", 32'(bus.dup_err), 32'(EXP_DUP));
        tick();
        checkOutput("t6_dup_sticky", 32'(bus.dup_err), 32'(EXP_DUP));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("t6_dup_flush", 32'(bus.dup_err), 32'(EXP_DUP));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t6_dup_rst", 32'(bus.dup_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Transmit end of the common data bus (CDB).
- Collects completed results (ROB index + 16-bit value) from N_SRC functional units. Each unit has its own small result FIFO.
- Each cycle, grants up to N_LANES results round-robin and drives them on the registered 4-lane CDB. Reservation stations and the ROB snoop that bus.

Parameters:
- N_SRC, 6, number of functional-unit result sources.
- N_LANES, 4, CDB lanes driven per cycle; must match the consumer lane count.
- DEPTH, 2, entries per source FIFO (power of two, ≥2).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous squash of all buffered and in-flight results.
- src_valid[0:N_SRC-1]  in  1 each  source presents a result.
- src_rob_index[0:N_SRC-1]  in  4 each  ROB index of the result.
- src_result[0:N_SRC-1]  in  16 each  result value.
- src_ready[0:N_SRC-1]  out  1 each  source FIFO can accept; push = valid & ready.
- cdb_valid[0:N_LANES-1]  out  1 each  lane carries a result this cycle.
- cdb_rob_index[0:N_LANES-1]  out  4 each  broadcast ROB index.
- cdb_result[0:N_LANES-1]  out  16 each  broadcast value.
- cdb_busy  out  1  any source FIFO non-empty (status only).
- dup_err  out  1  sticky duplicate-tag flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at posedge):
  - all FIFO counts 0;
  - all cdb_valid=0, cdb_rob_index=0, cdb_result=0;
  - rr_ptr=0, dup_err=0.
  - src_ready reads 1 in the cycle after reset.
- src_ready[s] = (count[s] < DEPTH). It is a function of registered count only, so there is no combinational path from valid or grant.
- Push and pop on the same FIFO in the same cycle is legal. The count is unchanged; a FIFO at DEPTH still reports ready=0 that cycle.
- Arbitration is combinational from FIFO heads, and the CDB outputs are registered.
  - Latency: push at edge t makes the entry poppable in cycle t+1. It appears on the CDB after edge t+2 at the earliest.
- Grant selection:
  - Scan sources starting at rr_ptr, wrapping modulo N_SRC.
  - The first N_LANES non-empty sources are granted, one entry per source per cycle.
  - The k-th granted source drives lane k; lanes above the grant count get cdb_valid=0.
  - Ungranted lanes hold index/result at 0.
- Granted FIFOs pop at the same edge the lanes are loaded.
- rr_ptr update:
  - If ≥1 grant: rr_ptr ← (last granted source + 1) mod N_SRC.
  - With no grants, rr_ptr holds.
  - Starvation bound: a non-empty source is granted within ceil(N_SRC/N_LANES) cycles.
- Each FIFO is strictly in order within its source. No ordering is guaranteed across sources.
- CDB lanes are valid for exactly one cycle per result; there is no backpressure from consumers.
- flush=1 at posedge:
  - all FIFO counts ← 0;
  - all cdb_valid ← 0;
  - pushes that cycle are dropped;
  - rr_ptr ← 0; dup_err unaffected.
- If rst_n=0 and flush=1 together, reset wins.
- Reset mid-operation discards all buffered results; no partial broadcast occurs.
- cdb_busy = OR of (count[s] != 0), from registered state.

Optional Feature:
- Macro: CDB_DUP_CHECK_EN.
- Defined:
  - Each cycle, compare the ROB indices of all granted lanes pairwise.
  - Any match sets dup_err ← 1 at the same edge the lanes load. It stays set until rst_n.
  - The broadcast proceeds unchanged.
- Undefined: dup_err is tied to 0 and no comparators are built.

Decomposition:
- Package cdb_pkg:
  - ROB_IDX_W=4, DATA_W=16, CDB_LANES=4;
  - packed struct cdb_entry_t {rob_index, result};
  - function next_rr(ptr, n).
- Sub-module cdb_src_fifo, instantiated N_SRC times:
  - DEPTH-entry circular buffer of cdb_entry_t;
  - push/pop/flush, count, head, not_full.
- The top level holds the round-robin grant logic, lane registers and dup check.

Test Plan:
1. Single push, source 2, index 5, result 0x1234 at edge 1 → cdb_valid[0]=1, index 5, 0x1234 after edge 3 only. All other lanes stay 0, and valid drops the next cycle.
2. All 6 sources push once with indices 0–5, rr_ptr=0 → first broadcast has lanes 0..3 = sources 0..3 (indices 0,1,2,3). The next cycle has lanes 0,1 = indices 4,5 and lanes 2,3 invalid; rr_ptr=0 afterward.
3. Source 1 pushes 3 back-to-back results (indices 7,8,9) with no grant possible → src_ready[1]=0 after the second push and the third push is held. Order on the CDB is 7, 8, 9.
4. Flush in the cycle lanes would load 3 results, with a simultaneous push on source 4 → all cdb_valid=0 next cycle, counts 0, and the source 4 entry never appears.
5. rst_n=0 asserted while FIFOs are full → every output reads 0 next cycle; src_ready all 1; dup_err=0.
6. CDB_DUP_CHECK_EN defined, sources 0 and 3 both carrying index 6 granted together → both lanes broadcast and dup_err=1, sticky until reset. With the macro undefined, dup_err stays 0.
